// File: rtl/up_counter15_pkg.sv
// Shared constants for the free-running up-counter.
package up_counter15_pkg;

   // Default counter width. Blocks that use q can size their inputs from this.
   localparam int unsigned UC15_WIDTH = 4;

endpackage : up_counter15_pkg

// File: rtl/up_counter15.sv
// Free-running binary up-counter with synchronous active-high reset.
// Counts 0 .. 2^WIDTH-1 and wraps to 0. There is no enable, no load and no carry-out.
module up_counter15
   import up_counter15_pkg::*;
#(
   parameter int unsigned WIDTH = UC15_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);

   logic [WIDTH-1:0] r_count;

   // Count register: clear on reset, otherwise increment; the carry out of the top bit is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + LP_ONE;
      end
   end

   assign q = r_count;

endmodule : up_counter15

// File: tb/tb_up_counter15.sv
// Directed bench for up_counter15: default 4-bit instance plus a 3-bit instance.
module tb_up_counter15;

   logic       clk;
   logic       reset;
   logic       reset3;
   logic [3:0] q;
   logic [2:0] q3;

   int unsigned n_checks;
   int unsigned n_errors;

   up_counter15 #(.WIDTH(4)) u_dut (
      .clk   (clk),
      .reset (reset),
      .q     (q)
   );

   up_counter15 #(.WIDTH(3)) u_dut3 (
      .clk   (clk),
      .reset (reset3),
      .q     (q3)
   );

   // 10 ns clock; rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Safety net so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      reset3   = 1'b1;

      // Reset across one rising edge
      @(negedge clk);
      check_val("reset_q0", 32'(q), 0);

      // Release and count 1,2,3; also confirm value holds through the high phase
      reset = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(posedge clk); #1;
         check_val("count_after_edge", 32'(q), 32'(i));
         @(negedge clk);
         check_val("count_at_negedge", 32'(q), 32'(i));
      end

      // Back to zero, then full wrap
      reset = 1'b1;
      @(negedge clk);
      check_val("rereset_q0", 32'(q), 0);
      reset = 1'b0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clk);
         check_val("wrap_climb", 32'(q), 32'(i));
      end
      check_val("wrap_at_15", 32'(q), 15);
      @(negedge clk);
      check_val("wrap_16th_edge", 32'(q), 0);
      @(negedge clk);
      check_val("wrap_17th_edge", 32'(q), 1);
      @(negedge clk);
      check_val("pre_mid_reset", 32'(q), 2);

      // Mid-count synchronous reset asserted half a clock before the edge
      reset = 1'b1;
      #1;
      check_val("mid_reset_no_async", 32'(q), 2);
      @(negedge clk);
      check_val("mid_reset_q0", 32'(q), 0);
      reset = 1'b0;
      #1;
      check_val("mid_release_hold", 32'(q), 0);
      @(negedge clk);
      check_val("mid_release_1", 32'(q), 1);
      @(negedge clk);
      check_val("mid_release_2", 32'(q), 2);

      // Advance to 5, then a reset glitch inside the low phase
      repeat (3) @(negedge clk);
      check_val("pre_glitch_5", 32'(q), 5);
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      #1;
      check_val("glitch_no_effect", 32'(q), 5);
      @(negedge clk);
      check_val("glitch_next_edge", 32'(q), 6);

      // Advance to 9, then hold reset across 3 edges
      repeat (3) @(negedge clk);
      check_val("pre_hold_9", 32'(q), 9);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("hold_reset_q0", 32'(q), 0);
      end
      reset = 1'b0;
      @(negedge clk);
      check_val("hold_release_1", 32'(q), 1);

      // 3-bit instance: reset, then 8 edges give 1..7, 0
      reset3 = 1'b1;
      @(negedge clk);
      check_val("w3_reset_q0", 32'(q3), 0);
      reset3 = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         check_val("w3_count", 32'(q3), 32'(i % 8));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_up_counter15
